// File: rtl/usb_fs_tx.sv
// Full-speed USB bit-level transmitter: SYNC, NRZI-encoded data with bit stuffing, then EOP.
// All pad-facing outputs are registered and only change on bit boundaries.
module usb_fs_tx #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       pkt_start,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       busy,
    output logic       usb_p_tx,
    output logic       usb_n_tx,
    output logic       usb_tx_en
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_PER_BIT - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    ones_q, ones_d;
    logic [1:0]    eop_q, eop_d;
    logic          level_q, level_d;
    logic          p_q, p_d, n_q, n_d, en_q, en_d, busy_q, busy_d, rdy_q, rdy_d;
    logic          bit_end_s, stuff_due_s, byte_end_s;
    logic          send_s, nbit_s, base_s, fix_p_s, fix_n_s;

    // State register with synchronous reset back to an idle J line.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            shift_q <= 8'h00;
            idx_q   <= 3'd0;
            ones_q  <= 3'd0;
            eop_q   <= 2'd0;
            level_q <= 1'b1;
            p_q     <= 1'b1;
            n_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            eop_q   <= eop_d;
            level_q <= level_d;
            p_q     <= p_d;
            n_q     <= n_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state logic: at each bit end choose the symbol for the following bit slot.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        eop_d   = eop_q;
        level_d = level_q;
        en_d    = en_q;
        busy_d  = busy_q;
        p_d     = p_q;
        n_d     = n_q;
        send_s  = 1'b0;
        nbit_s  = 1'b0;
        base_s  = level_q;
        fix_p_s = p_q;
        fix_n_s = n_q;

        bit_end_s   = (cnt_q == CNT_LAST);
        stuff_due_s = (ones_q == 3'd6);
        // idx stays at 7 through a trailing stuff bit, so the byte only ends once no stuff is due.
        byte_end_s  = (idx_q == 3'd7) &&
                      ((state_q == ST_SYNC) || ((state_q == ST_DATA) && !stuff_due_s));
        rdy_d       = (cnt_q == CNT_PRE) && byte_end_s;

        if ((state_q == ST_IDLE) || bit_end_s) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (pkt_start) begin
                    state_d = ST_SYNC;
                    idx_d   = 3'd0;
                    base_s  = 1'b1;
                    send_s  = 1'b1;
                    nbit_s  = 1'b0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    fix_p_s = 1'b1;
                    fix_n_s = 1'b0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (!bit_end_s) begin
                    send_s = 1'b0;
                end else if ((state_q == ST_DATA) && stuff_due_s) begin
                    send_s = 1'b1;
                    nbit_s = 1'b0;
                end else if (idx_q == 3'd7) begin
                    if (tx_data_valid) begin
                        state_d = ST_DATA;
                        shift_d = tx_data;
                        idx_d   = 3'd0;
                        send_s  = 1'b1;
                        nbit_s  = tx_data[0];
                    end else begin
                        state_d = ST_EOP;
                        eop_d   = 2'd0;
                        fix_p_s = 1'b0;
                        fix_n_s = 1'b0;
                    end
                end else if (state_q == ST_SYNC) begin
                    idx_d  = idx_q + 3'd1;
                    send_s = 1'b1;
                    nbit_s = (idx_q == 3'd6);
                end else begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    send_s  = 1'b1;
                    nbit_s  = shift_q[1];
                end
            end
            ST_EOP: begin
                if (!bit_end_s) begin
                    send_s = 1'b0;
                end else if (eop_q == 2'd2) begin
                    state_d = ST_IDLE;
                    level_d = 1'b1;
                    fix_p_s = 1'b1;
                    fix_n_s = 1'b0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    eop_d   = eop_q + 2'd1;
                    fix_p_s = (eop_q == 2'd1);
                    fix_n_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fix_p_s = 1'b1;
                fix_n_s = 1'b0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (send_s) begin
            level_d = nbit_s ? base_s : ~base_s;
            ones_d  = nbit_s ? (ones_q + 3'd1) : 3'd0;
            p_d     = level_d;
            n_d     = ~level_d;
        end else begin
            p_d = fix_p_s;
            n_d = fix_n_s;
        end
    end

    assign tx_data_ready = rdy_q;
    assign busy          = busy_q;
    assign usb_p_tx      = p_q;
    assign usb_n_tx      = n_q;
    assign usb_tx_en     = en_q;
endmodule

// File: tb/tb_usb_fs_tx.sv
// Self-checking bench for usb_fs_tx: directed and randomized packets against a symbol-level model.
module tb_usb_fs_tx;
    localparam int CPB = 4;

    logic       clk_48mhz = 1'b0;
    logic       reset;
    logic       pkt_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       busy;
    logic       usb_p_tx;
    logic       usb_n_tx;
    logic       usb_tx_en;

    int tests = 0;
    int fails = 0;
    logic [7:0] pkt_q [$];

    always #5 clk_48mhz = ~clk_48mhz;

    usb_fs_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk_48mhz    (clk_48mhz),
        .reset        (reset),
        .pkt_start    (pkt_start),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready),
        .busy         (busy),
        .usb_p_tx     (usb_p_tx),
        .usb_n_tx     (usb_n_tx),
        .usb_tx_en    (usb_tx_en)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends pkt_q as one packet; exp_len < 0 means use the model length only, rep_at >= 0 re-pulses pkt_start.
    task automatic run_packet(input string name, input int exp_len, input int rep_at);
        logic       lbit_q [$];
        logic       bnd_q [$];
        logic [1:0] sym_q [$];
        int         run;
        logic       lvl;
        int         len;
        int         nb;
        int         idx;
        bit         pending;
        int         en_cnt;
        int         rdy_cnt;
        logic       exp_rdy;

        // Logical bit stream: SYNC, then each byte LSB first with a 0 inserted after six 1s.
        for (int b = 0; b < 8; b++) begin
            lbit_q.push_back(b == 7);
            bnd_q.push_back(b == 7);
        end
        run = 1;
        foreach (pkt_q[k]) begin
            for (int b = 0; b < 8; b++) begin
                lbit_q.push_back(pkt_q[k][b]);
                bnd_q.push_back(1'b0);
                run = pkt_q[k][b] ? run + 1 : 0;
                if (run == 6) begin
                    lbit_q.push_back(1'b0);
                    bnd_q.push_back(1'b0);
                    run = 0;
                end
            end
            bnd_q[bnd_q.size() - 1] = 1'b1;
        end
        lvl = 1'b1;
        foreach (lbit_q[s]) begin
            if (!lbit_q[s]) lvl = ~lvl;
            sym_q.push_back({lvl, ~lvl});
        end
        sym_q.push_back(2'b00);
        sym_q.push_back(2'b00);
        sym_q.push_back(2'b10);
        for (int e = 0; e < 3; e++) bnd_q.push_back(1'b0);
        len = sym_q.size() * CPB;

        nb      = pkt_q.size();
        idx     = 0;
        pending = 1'b0;
        en_cnt  = 0;
        rdy_cnt = 0;
        tx_data_valid = (nb > 0);
        tx_data       = (nb > 0) ? pkt_q[0] : 8'h00;
        pkt_start = 1'b1;
        @(posedge clk_48mhz);
        #1;
        pkt_start = 1'b0;

        for (int i = 0; i < len; i++) begin
            if (pending) begin
                idx++;
                pending       = 1'b0;
                tx_data_valid = (idx < nb);
                tx_data       = (idx < nb) ? pkt_q[idx] : 8'h00;
            end
            exp_rdy = ((i % CPB) == (CPB - 1)) && bnd_q[i / CPB];
            check($sformatf("%s line cyc%0d", name, i),
                  32'({usb_tx_en, busy, usb_p_tx, usb_n_tx}), 32'({2'b11, sym_q[i / CPB]}));
            check($sformatf("%s ready cyc%0d", name, i), 32'(tx_data_ready), 32'(exp_rdy));
            if (usb_tx_en) en_cnt++;
            if (tx_data_ready) rdy_cnt++;
            if (tx_data_ready && tx_data_valid) pending = 1'b1;
            pkt_start = (i == rep_at);
            @(posedge clk_48mhz);
            #1;
        end
        pkt_start = 1'b0;
        if (pending) idx++;
        tx_data_valid = 1'b0;
        tx_data       = 8'h00;

        check({name, " idle after EOP"}, 32'({usb_tx_en, busy, usb_p_tx, usb_n_tx}), 32'(4'b0010));
        check({name, " tx_en cycles"}, 32'(en_cnt), 32'(len));
        if (exp_len >= 0) check({name, " packet length"}, 32'(en_cnt), 32'(exp_len));
        check({name, " bytes consumed"}, 32'(idx), 32'(nb));
        check({name, " ready pulses"}, 32'(rdy_cnt), 32'(nb + 1));
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        pkt_start     = 1'b0;
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        repeat (3) @(posedge clk_48mhz);
        #1;
        check("reset values", 32'({usb_p_tx, usb_n_tx, usb_tx_en, tx_data_ready, busy}), 32'(5'b10000));
        reset = 1'b0;
        @(posedge clk_48mhz);
        #1;
        check("idle after reset", 32'({usb_p_tx, usb_n_tx, usb_tx_en, tx_data_ready, busy}), 32'(5'b10000));

        pkt_q = {};
        run_packet("zero-byte", 44, -1);
        pkt_q = {8'hD2};
        run_packet("ack", 76, -1);
        pkt_q = {8'hFF};
        run_packet("ff", 80, -1);
        pkt_q = {8'hFF, 8'hFF};
        run_packet("ff-ff", 116, -1);
        pkt_q = {8'h3F, 8'hFC, 8'h7E};
        run_packet("repulse", -1, 40);

        for (int k = 0; k < 8; k++) begin
            pkt_q = {};
            n = $urandom_range(0, 4);
            for (int j = 0; j < n; j++) begin
                pkt_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            end
            run_packet($sformatf("rand%0d", k), -1, (k % 2 == 1) ? int'($urandom_range(1, 40)) : -1);
        end

        // Abort a packet in its data phase with reset.
        tx_data       = 8'hA5;
        tx_data_valid = 1'b1;
        pkt_start     = 1'b1;
        @(posedge clk_48mhz);
        #1;
        pkt_start = 1'b0;
        repeat (12 * CPB) @(posedge clk_48mhz);
        #1;
        check("busy before reset", 32'({usb_tx_en, busy}), 32'(2'b11));
        reset = 1'b1;
        @(posedge clk_48mhz);
        #1;
        reset         = 1'b0;
        tx_data_valid = 1'b0;
        check("reset mid-packet", 32'({usb_p_tx, usb_n_tx, usb_tx_en, tx_data_ready, busy}), 32'(5'b10000));
        for (int i = 0; i < 3 * CPB; i++) begin
            @(posedge clk_48mhz);
            #1;
            check($sformatf("no EOP after reset cyc%0d", i),
                  32'({usb_p_tx, usb_n_tx, usb_tx_en}), 32'(3'b100));
        end
        pkt_q = {8'h5A, 8'hFF};
        run_packet("after-reset", -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
